ckong_dl_ctrl: RTL
==================

// Module: ckong_dl_ctrl
// PURPOSE
//  Sequences the HPS ROM download stream into the ckong core's ROM write port.
//  Decodes each byte into one of four ROM regions and gates writes outside the ROM image.
//  Holds the core in reset during download and for a fixed settle time afterwards.
//  Flags incomplete or oversize images. Sits between hps_io and ckong on clk_sys.
// PARAMETERS
//  ROM_SIZE     17'h11000  total image bytes; writes at ioctl_addr >= ROM_SIZE are dropped
//  HOLD_CYCLES  1024       clk_sys cycles cpu_reset stays high after download/reset ends
//  ROM_INDEX    8'd0       ioctl_index value that selects the ROM download
//  EXPECT_SUM   16'h0000   expected byte sum (used only with CKONG_DL_CHECKSUM_EN)
// PORTS
//  clk_sys        in   1   system clock (12 MHz core clock)
//  reset          in   1   asynchronous, active-high reset
//  rst_req        in   1   synchronous soft reset request (OSD reset / user button)
//  ioctl_download in   1   download window active
//  ioctl_index    in   8   download target index
//  ioctl_wr       in   1   one-cycle byte strobe
//  ioctl_addr     in   25  byte address
//  ioctl_dout     in   8   byte data
//  dn_addr        out  17  registered ROM write address
//  dn_data        out  8   registered ROM write data
//  dn_wr          out  1   registered one-cycle ROM write strobe
//  dn_region      out  4   one-hot region of current write: [0]PRG [1]CHR [2]SPR [3]SND
//  cpu_reset      out  1   core reset
//  dl_busy        out  1   FSM in S_LOAD
//  dl_error       out  2   [0] byte count != ROM_SIZE at end; [1] out-of-range write seen
// BEHAVIOUR
//  Reset values: dn_addr=0, dn_data=0, dn_wr=0, dn_region=0, cpu_reset=1, dl_busy=0, dl_error=0.
//  After reset: FSM=S_HOLD, hold_cnt=0, byte_cnt=0.
//  FSM states:
//   S_HOLD: cpu_reset=1; hold_cnt++.
//     -> S_RUN when hold_cnt==HOLD_CYCLES-1.
//     -> S_LOAD when a download starts (takes priority).
//   S_RUN: cpu_reset=0.
//     -> S_LOAD when ioctl_download=1 and ioctl_index==ROM_INDEX.
//     -> S_HOLD (hold_cnt=0) when rst_req=1.
//   S_LOAD: cpu_reset=1, dl_busy=1. Entry clears byte_cnt and dl_error (and the sum).
//     -> S_HOLD (hold_cnt=0) when ioctl_download falls.
//  Write path (1-cycle latency):
//   A write is accepted when ioctl_wr & ioctl_download & index match & ioctl_addr<ROM_SIZE.
//   On the next edge after an accepted write: dn_wr=1, dn_addr=ioctl_addr[16:0],
//   dn_data=ioctl_dout, dn_region from the package region table.
//   dn_wr is low in every other cycle.
//  Out of range: addr>=ROM_SIZE while downloading drops the write (no dn_wr) and sets dl_error[1].
//  byte_cnt counts accepted writes and saturates at 2^17-1. Address order is not checked.
//  A write in the same cycle ioctl_download falls is dropped (download is already low).
//  End of download: dl_error[0] <= (byte_cnt != ROM_SIZE), evaluated on the S_LOAD->S_HOLD edge.
//  rst_req during S_LOAD is ignored. rst_req during S_HOLD restarts hold_cnt at 0.
//  Async reset mid-download aborts the download: FSM to S_HOLD; no partial dn_wr is emitted.
//  Non-matching ioctl_index downloads are ignored entirely; FSM state is unchanged.
// CONFIGURATION
//  CKONG_DL_CHECKSUM_EN defined:
//   16-bit wrapping sum of accepted bytes, cleared on S_LOAD entry.
//   dl_error widens to 3 bits; [2] is set at end of download when sum != EXPECT_SUM.
//  CKONG_DL_CHECKSUM_EN undefined: no sum logic, dl_error stays 2 bits, EXPECT_SUM is unused.
// STRUCTURE
//  Package ckong_dl_pkg:
//   dl_state_t enum {S_HOLD, S_RUN, S_LOAD}
//   region base/limit constants:
//    PRG  0x00000-0x05FFF
//    CHR  0x06000-0x09FFF
//    SPR  0x0A000-0x0DFFF
//    SND  0x0E000-0x10FFF
//   function region_decode(addr) -> 4-bit one-hot.
//  One sub-module: ckong_dl_hold_timer (loadable cycle counter with done flag), used for S_HOLD.
// TESTING
//  1. Release reset, idle -> cpu_reset=1 for exactly 1024 cycles, then 0; dl_busy=0.
//  2. Download 0x11000 bytes, index 0, addr 0..0x10FFF -> 0x11000 dn_wr pulses, each 1 cycle
//     after ioctl_wr. Region at addr 0x05FFF=0001, 0x06000=0010, 0x0E000=1000.
//     dl_error=0; cpu_reset falls 1024 cycles after download falls.
//  3. Download stopped after 0x8000 bytes -> dl_error[0]=1. A write at addr 0x11000 -> no dn_wr,
//     dl_error[1]=1.
//  4. Download with ioctl_index=1 -> no dn_wr; cpu_reset stays 0 in S_RUN.
//  5. Assert reset mid-download at byte 0x100 -> all outputs take reset values immediately.
//     Restarted full download completes with dl_error=0.
//  6. (CKONG_DL_CHECKSUM_EN) bytes 0x01,0xFF with ROM_SIZE=2, EXPECT_SUM=16'h0100 -> dl_error=0.
//     With EXPECT_SUM=0 -> dl_error[2]=1.

Source files
------------

// File: rtl/ckong_dl_pkg.sv
// Shared types and ROM region map for the ckong download controller.
// CKONG_DL_CHECKSUM_EN widens the error vector to carry the checksum flag.
package ckong_dl_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_LOAD = 2'd2
    } dl_state_t;

    // Regions are contiguous from address 0, so only the inclusive upper limits are needed.
    localparam logic [16:0] PRG_LIMIT = 17'h05FFF;
    localparam logic [16:0] CHR_LIMIT = 17'h09FFF;
    localparam logic [16:0] SPR_LIMIT = 17'h0DFFF;
    localparam logic [16:0] SND_LIMIT = 17'h10FFF;

    localparam logic [3:0] REGION_PRG = 4'b0001;
    localparam logic [3:0] REGION_CHR = 4'b0010;
    localparam logic [3:0] REGION_SPR = 4'b0100;
    localparam logic [3:0] REGION_SND = 4'b1000;

`ifdef CKONG_DL_CHECKSUM_EN
    localparam int ERR_W = 3;
`else
    localparam int ERR_W = 2;
`endif

    function automatic logic [3:0] region_decode(input logic [16:0] addr);
        logic [3:0] r;
        r = 4'b0000;
        if (addr <= PRG_LIMIT)      r = REGION_PRG;
        else if (addr <= CHR_LIMIT) r = REGION_CHR;
        else if (addr <= SPR_LIMIT) r = REGION_SPR;
        else if (addr <= SND_LIMIT) r = REGION_SND;
        return r;
    endfunction

endpackage

// File: rtl/ckong_dl_hold_timer.sv
// Loadable up-counter that raises done after CYCLES counting cycles since the last load.
module ckong_dl_hold_timer #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == CW'(CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (en && !done)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ckong_dl_ctrl.sv
// HPS ROM download sequencer for ckong: region-tagged ROM writes, core reset hold, error flags.
// Define CKONG_DL_CHECKSUM_EN to add the byte-sum check on dl_error[2].
module ckong_dl_ctrl
    import ckong_dl_pkg::*;
#(
    parameter logic [16:0] ROM_SIZE    = 17'h11000,
    parameter int          HOLD_CYCLES = 1024,
    parameter logic [7:0]  ROM_INDEX   = 8'd0
`ifdef CKONG_DL_CHECKSUM_EN
    ,
    parameter logic [15:0] EXPECT_SUM  = 16'h0000
`endif
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             rst_req,
    input  logic             ioctl_download,
    input  logic [7:0]       ioctl_index,
    input  logic             ioctl_wr,
    input  logic [24:0]      ioctl_addr,
    input  logic [7:0]       ioctl_dout,
    output logic [16:0]      dn_addr,
    output logic [7:0]       dn_data,
    output logic             dn_wr,
    output logic [3:0]       dn_region,
    output logic             cpu_reset,
    output logic             dl_busy,
    output logic [ERR_W-1:0] dl_error
);
    dl_state_t        state_q, state_d;
    logic             hold_load, hold_done;
    logic [16:0]      byte_cnt_q, byte_cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [16:0]      dn_addr_q, dn_addr_d;
    logic [7:0]       dn_data_q, dn_data_d;
    logic             dn_wr_q, dn_wr_d;
    logic [3:0]       dn_region_q, dn_region_d;
`ifdef CKONG_DL_CHECKSUM_EN
    logic [15:0]      sum_q, sum_d;
`endif
    logic dl_match, in_range, wr_ok, wr_oor, load_entry, load_exit;

    assign dl_match   = ioctl_download && (ioctl_index == ROM_INDEX);
    assign in_range   = ioctl_addr < {8'd0, ROM_SIZE};
    assign wr_ok      = ioctl_wr && dl_match && in_range;
    assign wr_oor     = ioctl_wr && dl_match && !in_range;
    assign load_entry = (state_q != S_LOAD) && (state_d == S_LOAD);
    assign load_exit  = (state_q == S_LOAD) && (state_d != S_LOAD);

    ckong_dl_hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk  (clk_sys),
        .rst  (reset),
        .load (hold_load),
        .en   (state_q == S_HOLD),
        .done (hold_done)
    );

    // Timer is parked at zero outside S_HOLD so every entry into S_HOLD starts a full hold.
    always_comb begin
        state_d   = state_q;
        hold_load = 1'b1;
        case (state_q)
            S_HOLD: begin
                hold_load = rst_req;
                if (dl_match)       state_d = S_LOAD;
                else if (!rst_req && hold_done) state_d = S_RUN;
            end
            S_RUN: begin
                if (dl_match)     state_d = S_LOAD;
                else if (rst_req) state_d = S_HOLD;
            end
            S_LOAD: begin
                if (!ioctl_download) state_d = S_HOLD;
            end
            default: state_d = S_HOLD;
        endcase
    end

    // Clearing on entry happens before accumulation so a write on the entry edge still counts.
    always_comb begin
        byte_cnt_d = load_entry ? '0 : byte_cnt_q;
        if (wr_ok && (byte_cnt_d != '1))
            byte_cnt_d = byte_cnt_d + 17'd1;

        err_d = load_entry ? '0 : err_q;
        if (wr_oor)    err_d[1] = 1'b1;
        if (load_exit) err_d[0] = (byte_cnt_q != ROM_SIZE);
`ifdef CKONG_DL_CHECKSUM_EN
        sum_d = load_entry ? '0 : sum_q;
        if (wr_ok)     sum_d = sum_d + {8'd0, ioctl_dout};
        if (load_exit) err_d[2] = (sum_q != EXPECT_SUM);
`endif

        dn_wr_d     = wr_ok;
        dn_addr_d   = dn_addr_q;
        dn_data_d   = dn_data_q;
        dn_region_d = dn_region_q;
        if (wr_ok) begin
            dn_addr_d   = ioctl_addr[16:0];
            dn_data_d   = ioctl_dout;
            dn_region_d = region_decode(ioctl_addr[16:0]);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_HOLD;
            byte_cnt_q  <= '0;
            err_q       <= '0;
            dn_addr_q   <= '0;
            dn_data_q   <= '0;
            dn_wr_q     <= 1'b0;
            dn_region_q <= '0;
`ifdef CKONG_DL_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            err_q       <= err_d;
            dn_addr_q   <= dn_addr_d;
            dn_data_q   <= dn_data_d;
            dn_wr_q     <= dn_wr_d;
            dn_region_q <= dn_region_d;
`ifdef CKONG_DL_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign dn_addr   = dn_addr_q;
    assign dn_data   = dn_data_q;
    assign dn_wr     = dn_wr_q;
    assign dn_region = dn_region_q;
    assign cpu_reset = (state_q != S_RUN);
    assign dl_busy   = (state_q == S_LOAD);
    assign dl_error  = err_q;

endmodule
